// File: rtl/fir_stream_ctrl_if.sv
// fir_stream_ctrl_if: host-side push/pop, FIR AXI-Stream and block status signals of fir_stream_ctrl.
interface fir_stream_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W = 10
);
  logic start;
  logic [LEN_W-1:0] data_len;
  logic done_clr;
  logic x_valid;
  logic x_ready;
  logic [DATA_W-1:0] x_data;
  logic y_valid;
  logic y_ready;
  logic [DATA_W-1:0] y_data;
  logic ss_tvalid;
  logic ss_tready;
  logic ss_tlast;
  logic [DATA_W-1:0] ss_tdata;
  logic sm_tvalid;
  logic sm_tready;
  logic sm_tlast;
  logic [DATA_W-1:0] sm_tdata;
  logic ap_start;
  logic ap_idle;
  logic ap_done;
  logic err;
  modport slave (
    input start, data_len, done_clr, x_valid, x_data, y_ready, ss_tready, sm_tvalid, sm_tdata, sm_tlast,
    output x_ready, y_valid, y_data, ss_tvalid, ss_tdata, ss_tlast, sm_tready, ap_start, ap_idle, ap_done, err
  );
  modport master (
    output start, data_len, done_clr, x_valid, x_data, y_ready, ss_tready, sm_tvalid, sm_tdata, sm_tlast,
    input x_ready, y_valid, y_data, ss_tvalid, ss_tdata, ss_tlast, sm_tready, ap_start, ap_idle, ap_done, err
  );
endinterface

// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: sequences one FIR run, buffering host X into the FIR and FIR Y back to the host.
module fir_stream_ctrl #(
  parameter int DATA_W = 32,
  parameter int LEN_W = 10,
  parameter int FIFO_DEPTH = 4
) (
  input logic axis_clk,
  input logic axis_rst_n,
  fir_stream_ctrl_if.slave io
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [LEN_W-1:0] len;
  logic [LEN_W:0] sent, recv, len_x, len_m1;
  logic [DATA_W-1:0] xm [FIFO_DEPTH];
  logic [DATA_W-1:0] ym [FIFO_DEPTH];
  logic [AW-1:0] xw, xr, yw, yr;
  logic [AW:0] xc, yc;
  logic start_acc, x_push, x_pop, y_push, y_pop, mis, ap_start_q, done_q, err_q;
  assign len_x = {1'b0, len};
  assign len_m1 = len_x - (LEN_W+1)'(1);
  assign start_acc = state == IDLE && io.start;
  // counts are powers of two, so the count MSB alone marks a full FIFO
  assign io.x_ready = state == RUN && !xc[AW] && (sent + (LEN_W+1)'(xc)) < len_x;
  assign io.ss_tvalid = state == RUN && |xc;
  assign io.ss_tdata = xm[xr];
  assign io.ss_tlast = io.ss_tvalid && sent == len_m1;
  assign io.sm_tready = (state == RUN || state == DRAIN) && !yc[AW];
  assign io.y_valid = |yc;
  assign io.y_data = ym[yr];
  assign x_push = io.x_valid && io.x_ready;
  assign x_pop = io.ss_tvalid && io.ss_tready;
  assign y_push = io.sm_tvalid && io.sm_tready;
  assign y_pop = io.y_valid && io.y_ready;
  assign mis = y_push && (io.sm_tlast != (recv == len_m1));
  assign io.ap_start = ap_start_q;
  assign io.ap_idle = state == IDLE || state == DONE;
  assign io.ap_done = done_q;
  assign io.err = err_q;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = io.start ? (io.data_len == '0 ? DONE : RUN) : IDLE;
      RUN: nxt = sent == len_x ? DRAIN : RUN;
      DRAIN: nxt = recv == len_x ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      state <= IDLE;
      len <= '0;
      sent <= '0;
      recv <= '0;
      ap_start_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      xw <= '0;
      xr <= '0;
      xc <= '0;
      yw <= '0;
      yr <= '0;
      yc <= '0;
    end else begin
      state <= nxt;
      if (start_acc) len <= io.data_len;
      sent <= start_acc ? '0 : sent + (LEN_W+1)'(x_pop);
      recv <= start_acc ? '0 : recv + (LEN_W+1)'(y_push);
      ap_start_q <= start_acc && io.data_len != '0;
      done_q <= start_acc ? io.data_len == '0 : (state == DRAIN && nxt == DONE) || (done_q && !io.done_clr);
      err_q <= !start_acc && (mis || (err_q && !io.done_clr));
      xw <= xw + AW'(x_push);
      xr <= xr + AW'(x_pop);
      xc <= xc + (AW+1)'(x_push) - (AW+1)'(x_pop);
      yw <= yw + AW'(y_push);
      yr <= yr + AW'(y_pop);
      yc <= yc + (AW+1)'(y_push) - (AW+1)'(y_pop);
    end
  always_ff @(posedge axis_clk) begin
    if (x_push) xm[xw] <= io.x_data;
    if (y_push) ym[yw] <= io.sm_tdata;
  end
endmodule
